multi_mode_counter: RTL and testbench

Game-style up/down counter with four counting modes, synchronous load, and win/loss tallies. A main counter steps by ±1 or ±2 each clock. Reaching all-ones is a win and reaching zero is a loss. Two score counters tally wins and losses; when either fills, the block declares game over, reports who finished it, and restarts the game. It sits as a self-contained leaf block driven by switches/registers, with outputs going to display or status logic.

---
 rtl/multi_mode_counter_pkg.sv | 19 +
 rtl/multi_mode_counter_score.sv | 35 +++
 rtl/multi_mode_counter.sv | 100 ++++++++++
 tb/tb_multi_mode_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_mode_counter_pkg.sv
// Shared encodings for multi_mode_counter.
//   mode_e : counting mode selected by the `mode` input
//   who_e  : which score counter filled and ended the last game
package multi_mode_counter_pkg;

   typedef enum logic [1:0] {
      UP1 = 2'b00,
      UP2 = 2'b01,
      DN1 = 2'b10,
      DN2 = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      WHO_NONE = 2'b00,
      WHO_LOSE = 2'b01,
      WHO_WIN  = 2'b10
   } who_e;

endpackage

// File: rtl/multi_mode_counter_score.sv
// score_counter: C-bit event counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   inc   : count one event this edge
//   clr   : synchronous clear, wins over inc
//   full  : combinational, high on the edge where the counter steps to all-ones
module score_counter #(
   parameter int C = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic full
);

   // value one below all-ones; an increment from here fills the counter
   localparam logic [C-1:0] PRE_FULL = ~C'(1);

   logic [C-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = cnt_q + C'(1);
   end

   assign full = inc & ~clr & (cnt_q == PRE_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multi_mode_counter.sv
// multi_mode_counter: up/down game counter with win/loss tallies.
//   mode     : 00 +1, 01 +2, 10 -1, 11 -2 (modulo 2^W)
//   init     : synchronous load of init_val into count
//   who      : finisher of the last game (00 none, 10 winner, 01 loser)
//   winner   : count is all-ones (masked during gameover)
//   loser    : count is zero (masked during gameover)
//   count    : main counter
//   gameover : one-cycle pulse after a score counter fills; next edge restarts
module multi_mode_counter
   import multi_mode_counter_pkg::*;
#(
   parameter int MULTI_MODE_COUNTER_WIDTH = 5,
   parameter int COUNTERS_WIDTH           = 4
) (
   input  logic [1:0]                          mode,
   input  logic                                init,
   input  logic [MULTI_MODE_COUNTER_WIDTH-1:0] init_val,
   input  logic                                clk,
   input  logic                                rst,
   output logic [1:0]                          who,
   output logic                                winner,
   output logic                                loser,
   output logic [MULTI_MODE_COUNTER_WIDTH-1:0] count,
   output logic                                gameover
);

   localparam int W = MULTI_MODE_COUNTER_WIDTH;

   logic [W-1:0] count_q, count_d;
   logic         gameover_q, gameover_d;
   logic [1:0]   who_q, who_d;
   logic         win_full, lose_full;

   // decodes of the registered count; suppressed during the gameover cycle
   // so no score event is taken while the restart is pending
   assign winner = (count_q == {W{1'b1}}) & ~gameover_q;
   assign loser  = (count_q == '0)        & ~gameover_q;

   score_counter #(.C(COUNTERS_WIDTH)) u_win (
      .clk   (clk),
      .rst_n (rst),
      .inc   (winner),
      .clr   (gameover_q),
      .full  (win_full)
   );

   score_counter #(.C(COUNTERS_WIDTH)) u_lose (
      .clk   (clk),
      .rst_n (rst),
      .inc   (loser),
      .clr   (gameover_q),
      .full  (lose_full)
   );

   always_comb begin
      count_d    = count_q;
      gameover_d = 1'b0;
      who_d      = who_q;

      if (gameover_q) begin
         count_d = '0;
      end else if (init) begin
         count_d = init_val;
      end else begin
         case (mode_e'(mode))
            UP1:     count_d = count_q + W'(1);
            UP2:     count_d = count_q + W'(2);
            DN1:     count_d = count_q - W'(1);
            DN2:     count_d = count_q - W'(2);
            default: count_d = count_q;
         endcase
      end

      // winner and loser are exclusive, so at most one full fires per edge
      if (win_full) begin
         gameover_d = 1'b1;
         who_d      = WHO_WIN;
      end else if (lose_full) begin
         gameover_d = 1'b1;
         who_d      = WHO_LOSE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         gameover_q <= 1'b0;
         who_q      <= WHO_NONE;
      end else begin
         count_q    <= count_d;
         gameover_q <= gameover_d;
         who_q      <= who_d;
      end
   end

   assign count    = count_q;
   assign gameover = gameover_q;
   assign who      = who_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
module tb_multi_mode_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       init = 1'b0;
   logic [4:0] init_val = 5'd0;
   logic [1:0] who;
   logic       winner, loser, gameover;
   logic [4:0] count;

   int total  = 0;
   int passed = 0;

   multi_mode_counter #(
      .MULTI_MODE_COUNTER_WIDTH(5),
      .COUNTERS_WIDTH(4)
   ) dut (
      .mode     (mode),
      .init     (init),
      .init_val (init_val),
      .clk      (clk),
      .rst      (rst),
      .who      (who),
      .winner   (winner),
      .loser    (loser),
      .count    (count),
      .gameover (gameover)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called at posedge+1 (or time 0); returns before the next edge
   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #1;
      rst = 1'b0;
      #1;
      total++; if (count !== 5'd0)   $display("FAIL reset count got=%0d exp=0", count); else passed++;
      total++; if (who !== 2'b00)    $display("FAIL reset who got=%b exp=00", who); else passed++;
      total++; if (gameover !== 1'b0) $display("FAIL reset gameover got=%b exp=0", gameover); else passed++;
      total++; if (loser !== 1'b1)   $display("FAIL reset loser got=%b exp=1", loser); else passed++;
      total++; if (winner !== 1'b0)  $display("FAIL reset winner got=%b exp=0", winner); else passed++;
      tick();
      total++; if (count !== 5'd0)   $display("FAIL reset_held count got=%0d exp=0", count); else passed++;
      #1;
      rst = 1'b1;
      #1;
   endtask

   // mode 00: 15th loss (at cycle 448) ends the game, who=01
   task automatic test_up1();
      logic [4:0] e;
      do_reset();
      mode = 2'b00; init = 1'b0;
      for (int i = 0; i <= 448; i++) begin
         e = 5'(i % 32);
         total++; if (count !== e) $display("FAIL up1 count cyc=%0d got=%0d exp=%0d", i, count, e); else passed++;
         total++; if (winner !== (e == 5'd31)) $display("FAIL up1 winner cyc=%0d got=%b exp=%b", i, winner, e == 5'd31); else passed++;
         total++; if (loser !== (e == 5'd0)) $display("FAIL up1 loser cyc=%0d got=%b exp=%b", i, loser, e == 5'd0); else passed++;
         total++; if (gameover !== 1'b0) $display("FAIL up1 early_gameover cyc=%0d got=%b exp=0", i, gameover); else passed++;
         tick();
      end
      total++; if (gameover !== 1'b1) $display("FAIL up1 gameover got=%b exp=1", gameover); else passed++;
      total++; if (who !== 2'b01)     $display("FAIL up1 who got=%b exp=01", who); else passed++;
      total++; if (loser !== 1'b0 || winner !== 1'b0) $display("FAIL up1 mask got=%b%b exp=00", winner, loser); else passed++;
      tick();
      total++; if (count !== 5'd0)    $display("FAIL up1 restart_count got=%0d exp=0", count); else passed++;
      total++; if (gameover !== 1'b0) $display("FAIL up1 pulse_len got=%b exp=0", gameover); else passed++;
      total++; if (who !== 2'b01)     $display("FAIL up1 who_hold got=%b exp=01", who); else passed++;
   endtask

   // mode 11: 0,30,28,...,2,0 ; loss every 16 cycles, 15th at cycle 224
   task automatic test_dn2();
      logic [4:0] e;
      do_reset();
      mode = 2'b11; init = 1'b0;
      for (int i = 0; i <= 224; i++) begin
         e = 5'((32 * 16 - 2 * i) % 32);
         total++; if (count !== e) $display("FAIL dn2 count cyc=%0d got=%0d exp=%0d", i, count, e); else passed++;
         total++; if (winner !== 1'b0) $display("FAIL dn2 winner cyc=%0d got=%b exp=0", i, winner); else passed++;
         total++; if (loser !== (i % 16 == 0)) $display("FAIL dn2 loser cyc=%0d got=%b exp=%b", i, loser, i % 16 == 0); else passed++;
         total++; if (gameover !== 1'b0) $display("FAIL dn2 early_gameover cyc=%0d got=%b exp=0", i, gameover); else passed++;
         tick();
      end
      total++; if (gameover !== 1'b1) $display("FAIL dn2 gameover got=%b exp=1", gameover); else passed++;
      total++; if (who !== 2'b01)     $display("FAIL dn2 who got=%b exp=01", who); else passed++;
      total++; if (count !== 5'd30)   $display("FAIL dn2 go_count got=%0d exp=30", count); else passed++;
   endtask

   // mode 10, repeated loads of 31: 15 wins end the game with who=10
   task automatic test_dn1_wins();
      do_reset();
      mode = 2'b10; init_val = 5'd31;
      for (int k = 1; k <= 15; k++) begin
         init = 1'b1;
         tick();
         init = 1'b0;
         total++; if (count !== 5'd31) $display("FAIL dn1 load k=%0d got=%0d exp=31", k, count); else passed++;
         total++; if (winner !== 1'b1) $display("FAIL dn1 winner k=%0d got=%b exp=1", k, winner); else passed++;
         tick();
         total++; if (count !== 5'd30) $display("FAIL dn1 step k=%0d got=%0d exp=30", k, count); else passed++;
         total++; if (gameover !== (k == 15)) $display("FAIL dn1 gameover k=%0d got=%b exp=%b", k, gameover, k == 15); else passed++;
      end
      total++; if (who !== 2'b10) $display("FAIL dn1 who got=%b exp=10", who); else passed++;
      tick();
      total++; if (count !== 5'd0 || gameover !== 1'b0) $display("FAIL dn1 restart got=%0d/%b exp=0/0", count, gameover); else passed++;
      total++; if (loser !== 1'b1) $display("FAIL dn1 restart_loser got=%b exp=1", loser); else passed++;
      total++; if (who !== 2'b10) $display("FAIL dn1 who_hold got=%b exp=10", who); else passed++;
   endtask

   // continues from the restart left by test_dn1_wins: 7 wins, then async reset
   task automatic test_reset_mid();
      logic [4:0] e;
      mode = 2'b10; init_val = 5'd31;
      for (int k = 1; k <= 7; k++) begin
         init = 1'b1;
         tick();
         init = 1'b0;
         tick();
      end
      total++; if (count !== 5'd30 || who !== 2'b10) $display("FAIL mid pre got=%0d/%b exp=30/10", count, who); else passed++;
      #3;
      rst = 1'b0;
      #1;
      total++; if (count !== 5'd0)    $display("FAIL mid count got=%0d exp=0", count); else passed++;
      total++; if (who !== 2'b00)     $display("FAIL mid who got=%b exp=00", who); else passed++;
      total++; if (gameover !== 1'b0) $display("FAIL mid gameover got=%b exp=0", gameover); else passed++;
      #1;
      rst = 1'b1;
      mode = 2'b00;
      for (int i = 0; i <= 448; i++) begin
         e = 5'(i % 32);
         total++; if (count !== e) $display("FAIL mid count cyc=%0d got=%0d exp=%0d", i, count, e); else passed++;
         total++; if (gameover !== 1'b0) $display("FAIL mid early_gameover cyc=%0d got=%b exp=0", i, gameover); else passed++;
         tick();
      end
      total++; if (gameover !== 1'b1 || who !== 2'b01) $display("FAIL mid gameover got=%b/%b exp=1/01", gameover, who); else passed++;
   endtask

   // mode 01 load 5: 5,7,...,31,1,3
   task automatic test_up2();
      logic [4:0] e;
      do_reset();
      mode = 2'b01; init_val = 5'd5; init = 1'b1;
      tick();
      init = 1'b0;
      for (int j = 0; j < 16; j++) begin
         e = 5'((5 + 2 * j) % 32);
         total++; if (count !== e) $display("FAIL up2 count j=%0d got=%0d exp=%0d", j, count, e); else passed++;
         total++; if (winner !== (e == 5'd31)) $display("FAIL up2 winner j=%0d got=%b exp=%b", j, winner, e == 5'd31); else passed++;
         total++; if (loser !== 1'b0) $display("FAIL up2 loser j=%0d got=%b exp=0", j, loser); else passed++;
         tick();
      end
   endtask

   // every init_val in every mode, then one free step
   task automatic test_sweep();
      logic [4:0] v, e;
      int         step;
      do_reset();
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         step = (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 31 : 30;
         for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            init_val = v; init = 1'b1;
            tick();
            init = 1'b0;
            total++; if (count !== v) $display("FAIL sweep load m=%0d v=%0d got=%0d", m, k, count); else passed++;
            total++; if (winner !== (k == 31) || loser !== (k == 0))
               $display("FAIL sweep decode m=%0d v=%0d got=%b%b exp=%b%b", m, k, winner, loser, k == 31, k == 0); else passed++;
            tick();
            e = 5'((k + step) % 32);
            total++; if (count !== e) $display("FAIL sweep step m=%0d v=%0d got=%0d exp=%0d", m, k, count, e); else passed++;
            total++; if (gameover !== 1'b0) $display("FAIL sweep gameover m=%0d v=%0d got=%b exp=0", m, k, gameover); else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_up1();
      test_dn2();
      test_dn1_wins();
      test_reset_mid();
      test_up2();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
